prbs7_checker: RTL and testbench

PRBS7_CHECKER -- requirements
Module: prbs7_checker

---
 rtl/prbs7_checker.sv | 151 +++++++++++++++
 tb/tb_prbs7_checker.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs7_checker.sv
// PRBS7 (x^7+x^6+1) serial checker: seeds its reference from the stream, locks after
// a run of correct predictions, then counts bit errors against its own free-running reference.
//
// state    | meaning
// S_SEED   | loading 7 received bits into sr
// S_TRACK  | predicting from received bits, counting consecutive matches
// S_LOCKED | sr runs on its own predictions; mismatches are bit errors

module prbs7_checker #(
    parameter int LOCK_CNT    = 16,
    parameter int UNLOCK_ERRS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       din_valid,
    input  logic       din,
    input  logic       clear_cnt,
    output logic       locked,
    output logic       err_pulse,
    output logic [7:0] err_count,
    output logic [0:1] led
);

    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int RW = $clog2(UNLOCK_ERRS + 1);
    localparam logic [MW-1:0] MATCH_TC  = MW'(LOCK_CNT);
    localparam logic [MW-1:0] MATCH_ONE = MW'(1);
    localparam logic [RW-1:0] RUN_TC    = RW'(UNLOCK_ERRS);
    localparam logic [RW-1:0] RUN_ONE   = RW'(1);

    typedef enum logic [1:0] {
        S_SEED,
        S_TRACK,
        S_LOCKED
    } state_t;

    state_t        state, state_nxt;
    logic [6:0]    sr, sr_nxt;
    logic [2:0]    seed_cnt, seed_nxt;
    logic [MW-1:0] match_cnt, match_nxt, match_inc;
    logic [RW-1:0] run_cnt, run_nxt, run_inc;
    logic          predicted;
    logic          mismatch;
    logic          err_hit;
    logic          locked_nxt;
    logic [7:0]    err_count_nxt;

    assign predicted = sr[6] ^ sr[5];
    assign mismatch  = din ^ predicted;
    assign match_inc = match_cnt + MATCH_ONE;
    assign run_inc   = run_cnt + RUN_ONE;

    always_comb begin
        state_nxt = state;
        sr_nxt    = sr;
        seed_nxt  = seed_cnt;
        match_nxt = match_cnt;
        run_nxt   = run_cnt;
        err_hit   = 1'b0;

        if (din_valid) begin
            case (state)
                S_SEED: begin
                    sr_nxt = {sr[5:0], din};
                    if (seed_cnt == 3'd6) begin
                        seed_nxt  = 3'd0;
                        match_nxt = '0;
                        state_nxt = S_TRACK;
                    end else begin
                        seed_nxt = seed_cnt + 3'd1;
                    end
                end

                S_TRACK: begin
                    sr_nxt = {sr[5:0], din};
                    if (mismatch) begin
                        match_nxt = '0;
                    end else if (sr != 7'd0) begin
                        // an all-zero register predicts zeros forever, so it must never earn lock
                        match_nxt = match_inc;
                        if (match_inc == MATCH_TC) begin
                            run_nxt   = '0;
                            state_nxt = S_LOCKED;
                        end
                    end
                end

                S_LOCKED: begin
                    // shifting the prediction keeps a single flipped bit from corrupting later predictions
                    sr_nxt = {sr[5:0], predicted};
                    if (mismatch) begin
                        err_hit = 1'b1;
                        if (run_inc == RUN_TC) begin
                            seed_nxt  = 3'd0;
                            match_nxt = '0;
                            run_nxt   = '0;
                            state_nxt = S_SEED;
                        end else begin
                            run_nxt = run_inc;
                        end
                    end else begin
                        run_nxt = '0;
                    end
                end

                default: begin
                    seed_nxt  = 3'd0;
                    match_nxt = '0;
                    run_nxt   = '0;
                    state_nxt = S_SEED;
                end
            endcase
        end
    end

    always_comb begin
        err_count_nxt = err_count;
        if (clear_cnt) begin
            err_count_nxt = 8'd0;
        end else if (err_hit && (err_count != 8'hFF)) begin
            err_count_nxt = err_count + 8'd1;
        end
    end

    assign locked_nxt = (state_nxt == S_LOCKED);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_SEED;
            sr        <= 7'd0;
            seed_cnt  <= 3'd0;
            match_cnt <= '0;
            run_cnt   <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_count <= 8'd0;
            led       <= 2'b00;
        end else begin
            state     <= state_nxt;
            sr        <= sr_nxt;
            seed_cnt  <= seed_nxt;
            match_cnt <= match_nxt;
            run_cnt   <= run_nxt;
            locked    <= locked_nxt;
            err_pulse <= err_hit;
            err_count <= err_count_nxt;
            led       <= {locked_nxt, (err_count_nxt != 8'd0)};
        end
    end

endmodule

// File: tb/tb_prbs7_checker.sv
// Bench for prbs7_checker: two instances (default thresholds and UNLOCK_ERRS=1000)
// driven in parallel and compared every cycle against a stream-history reference model.

module tb_prbs7_checker;

    localparam int MAXN = 4096;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       din_valid = 1'b0;
    logic       din = 1'b0;
    logic       clear_cnt = 1'b0;

    logic       locked_a, err_pulse_a, locked_b, err_pulse_b;
    logic [7:0] err_count_a, err_count_b;
    logic [0:1] led_a, led_b;
    logic [11:0] obs_a, obs_b;

    int checks = 0;
    int failures = 0;

    prbs7_checker dut_a (
        .clk(clk), .reset(reset), .din_valid(din_valid), .din(din), .clear_cnt(clear_cnt),
        .locked(locked_a), .err_pulse(err_pulse_a), .err_count(err_count_a), .led(led_a)
    );

    prbs7_checker #(.LOCK_CNT(16), .UNLOCK_ERRS(1000)) dut_b (
        .clk(clk), .reset(reset), .din_valid(din_valid), .din(din), .clear_cnt(clear_cnt),
        .locked(locked_b), .err_pulse(err_pulse_b), .err_count(err_count_b), .led(led_b)
    );

    assign obs_a = {locked_a, err_pulse_a, err_count_a, led_a};
    assign obs_b = {locked_b, err_pulse_b, err_count_b, led_b};

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // reference model: per instance, the full history of bits the checker's register would hold
    bit         m_ref [2][MAXN];
    int         m_pos [2];
    int         m_mode [2];   // 0 seeding, 1 tracking, 2 locked
    int         m_seeds [2];
    int         m_match [2];
    int         m_runs [2];
    int         m_errs [2];
    bit         m_pulse [2];
    logic [11:0] exp_vec [2];

    task automatic model_push(input int k, input bit b);
        m_ref[k][m_pos[k]] = b;
        m_pos[k]++;
        if (m_pos[k] == MAXN) begin
            for (int j = 0; j < 7; j++) m_ref[k][j] = m_ref[k][MAXN-7+j];
            m_pos[k] = 7;
        end
    endtask

    task automatic model_step(input bit rst, input bit v, input bit d, input bit clr);
        int unl;
        bit pred;
        bit zero;
        for (int k = 0; k < 2; k++) begin
            unl = (k == 0) ? 4 : 1000;
            m_pulse[k] = 1'b0;
            if (rst) begin
                m_mode[k] = 0; m_seeds[k] = 0; m_match[k] = 0; m_runs[k] = 0; m_errs[k] = 0;
                for (int j = 0; j < 7; j++) m_ref[k][j] = 1'b0;
                m_pos[k] = 7;
            end else begin
                if (v) begin
                    pred = m_ref[k][m_pos[k]-7] ^ m_ref[k][m_pos[k]-6];
                    zero = 1'b1;
                    for (int j = 1; j <= 7; j++) if (m_ref[k][m_pos[k]-j]) zero = 1'b0;
                    if (m_mode[k] == 0) begin
                        model_push(k, d);
                        m_seeds[k]++;
                        if (m_seeds[k] == 7) begin m_mode[k] = 1; m_match[k] = 0; end
                    end else if (m_mode[k] == 1) begin
                        if (d == pred) begin
                            if (!zero) m_match[k]++;
                        end else begin
                            m_match[k] = 0;
                        end
                        model_push(k, d);
                        if (m_match[k] == 16) begin m_mode[k] = 2; m_runs[k] = 0; end
                    end else begin
                        model_push(k, pred);
                        if (d != pred) begin
                            m_pulse[k] = 1'b1;
                            if (m_errs[k] < 255) m_errs[k]++;
                            m_runs[k]++;
                            if (m_runs[k] == unl) begin
                                m_mode[k] = 0; m_seeds[k] = 0; m_match[k] = 0; m_runs[k] = 0;
                            end
                        end else begin
                            m_runs[k] = 0;
                        end
                    end
                end
                if (clr) m_errs[k] = 0;
            end
            exp_vec[k] = {(m_mode[k] == 2), m_pulse[k], m_errs[k][7:0], (m_mode[k] == 2), (m_errs[k] != 0)};
        end
    endtask

    // PRBS7 source: seed of seven ones, then b[n] = b[n-7] ^ b[n-6]
    bit g_q[$];
    int g_cnt;

    task automatic gen_reset();
        g_q.delete();
        g_cnt = 0;
    endtask

    function automatic bit gen_next();
        bit b;
        if (g_cnt < 7) b = 1'b1;
        else b = g_q[0] ^ g_q[1];
        g_cnt++;
        g_q.push_back(b);
        if (g_q.size() > 7) void'(g_q.pop_front());
        return b;
    endfunction

    task automatic drive(input bit rst, input bit v, input bit d, input bit clr);
        @(negedge clk);
        reset = rst; din_valid = v; din = d; clear_cnt = clr;
        @(posedge clk);
        model_step(rst, v, d, clr);
        #1;
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 0);
        drive(1, 1, 1, 1);
        checks++;
        if (obs_a !== 12'h000 || obs_b !== 12'h000) begin
            failures++;
            $display("FAIL reset_state: got a=%h b=%h expected 000", obs_a, obs_b);
        end
    endtask

    task automatic test_clean_lock();
        int lock_at = 0;
        bit b;
        gen_reset();
        drive(1, 0, 0, 0);
        for (int i = 1; i <= 1000; i++) begin
            b = gen_next();
            drive(0, 1, b, 0);
            checks++;
            if (obs_a !== exp_vec[0] || obs_b !== exp_vec[1]) begin
                failures++;
                $display("FAIL clean_lock bit %0d: got a=%h b=%h expected a=%h b=%h", i, obs_a, obs_b, exp_vec[0], exp_vec[1]);
            end
            if (locked_a && lock_at == 0) lock_at = i;
        end
        checks++;
        if (lock_at != 23) begin
            failures++;
            $display("FAIL clean_lock_time: locked after %0d bits, expected 23", lock_at);
        end
        checks++;
        if (err_count_a !== 8'd0 || locked_a !== 1'b1) begin
            failures++;
            $display("FAIL clean_no_errors: got count=%0d locked=%b expected count=0 locked=1", err_count_a, locked_a);
        end
    endtask

    task automatic test_single_flip();
        drive(0, 1, ~gen_next(), 0);
        checks++;
        if (err_pulse_a !== 1'b1 || err_count_a !== 8'd1 || locked_a !== 1'b1 || led_a !== 2'b11) begin
            failures++;
            $display("FAIL single_flip: got pulse=%b count=%0d locked=%b led=%b expected 1 1 1 11",
                     err_pulse_a, err_count_a, locked_a, led_a);
        end
        drive(0, 1, gen_next(), 0);
        checks++;
        if (err_pulse_a !== 1'b0 || err_count_a !== 8'd1 || obs_a !== exp_vec[0]) begin
            failures++;
            $display("FAIL single_flip_after: got a=%h expected pulse 0 count 1 (%h)", obs_a, exp_vec[0]);
        end
    endtask

    task automatic test_unlock();
        int relock_at = 0;
        drive(0, 1, gen_next(), 1);
        checks++;
        if (err_count_a !== 8'd0 || err_count_b !== 8'd0) begin
            failures++;
            $display("FAIL clear_cnt: got a=%0d b=%0d expected 0", err_count_a, err_count_b);
        end
        for (int i = 1; i <= 4; i++) begin
            drive(0, 1, ~gen_next(), 0);
            checks++;
            if (obs_a !== exp_vec[0] || obs_b !== exp_vec[1]) begin
                failures++;
                $display("FAIL unlock_flip %0d: got a=%h b=%h expected a=%h b=%h", i, obs_a, obs_b, exp_vec[0], exp_vec[1]);
            end
        end
        checks++;
        if (err_count_a !== 8'd4 || locked_a !== 1'b0 || err_pulse_a !== 1'b1 || locked_b !== 1'b1) begin
            failures++;
            $display("FAIL unlock_state: got count=%0d locked=%b pulse=%b locked_b=%b expected 4 0 1 1",
                     err_count_a, locked_a, err_pulse_a, locked_b);
        end
        for (int i = 1; i <= 60; i++) begin
            drive(0, 1, gen_next(), 0);
            checks++;
            if (obs_a !== exp_vec[0] || obs_b !== exp_vec[1]) begin
                failures++;
                $display("FAIL relock bit %0d: got a=%h b=%h expected a=%h b=%h", i, obs_a, obs_b, exp_vec[0], exp_vec[1]);
            end
            if (locked_a && relock_at == 0) relock_at = i;
        end
        checks++;
        if (relock_at != 23) begin
            failures++;
            $display("FAIL relock_time: relocked after %0d bits, expected 23", relock_at);
        end
    endtask

    task automatic test_saturate();
        for (int i = 1; i <= 300; i++) begin
            drive(0, 1, ~gen_next(), 0);
            checks++;
            if (obs_a !== exp_vec[0] || obs_b !== exp_vec[1]) begin
                failures++;
                $display("FAIL saturate bit %0d: got a=%h b=%h expected a=%h b=%h", i, obs_a, obs_b, exp_vec[0], exp_vec[1]);
            end
        end
        checks++;
        if (err_count_b !== 8'd255 || err_pulse_b !== 1'b1 || locked_b !== 1'b1) begin
            failures++;
            $display("FAIL saturate_hold: got count=%0d pulse=%b locked=%b expected 255 1 1", err_count_b, err_pulse_b, locked_b);
        end
        drive(0, 1, ~gen_next(), 1);
        checks++;
        if (err_count_b !== 8'd0 || err_pulse_b !== 1'b1 || led_b !== 2'b10) begin
            failures++;
            $display("FAIL clear_with_error: got count=%0d pulse=%b led=%b expected 0 1 10", err_count_b, err_pulse_b, led_b);
        end
    endtask

    task automatic test_zero_input();
        bit seen = 1'b0;
        drive(1, 0, 0, 0);
        for (int i = 1; i <= 120; i++) begin
            drive(0, 1, 0, 0);
            checks++;
            if (obs_a !== exp_vec[0] || obs_b !== exp_vec[1]) begin
                failures++;
                $display("FAIL zero_input bit %0d: got a=%h b=%h expected a=%h b=%h", i, obs_a, obs_b, exp_vec[0], exp_vec[1]);
            end
            if (locked_a || err_pulse_a || locked_b || err_pulse_b) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL zero_never_locks: got lock/pulse seen=%b expected 0", seen);
        end
    endtask

    task automatic test_gaps();
        int nvalid = 0;
        int lock_at = 0;
        bit v;
        gen_reset();
        drive(1, 0, 0, 0);
        for (int i = 0; i < 80; i++) begin
            v = (i % 2 == 0);
            if (v) begin
                nvalid++;
                drive(0, 1, gen_next(), 0);
            end else begin
                drive(0, 0, 1'($urandom_range(0, 1)), 0);
            end
            checks++;
            if (obs_a !== exp_vec[0] || obs_b !== exp_vec[1]) begin
                failures++;
                $display("FAIL gaps cyc %0d: got a=%h b=%h expected a=%h b=%h", i, obs_a, obs_b, exp_vec[0], exp_vec[1]);
            end
            if (locked_a && lock_at == 0) lock_at = nvalid;
        end
        checks++;
        if (lock_at != 23) begin
            failures++;
            $display("FAIL gaps_lock_time: locked after %0d valid bits, expected 23", lock_at);
        end
    endtask

    task automatic test_reset_locked();
        int lock_at = 0;
        gen_reset();
        drive(1, 0, 0, 0);
        for (int i = 0; i < 30; i++) drive(0, 1, gen_next(), 0);
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, ~gen_next(), 0);
            drive(0, 1, gen_next(), 0);
        end
        checks++;
        if (err_count_a !== 8'd5 || locked_a !== 1'b1 || obs_a !== exp_vec[0]) begin
            failures++;
            $display("FAIL pre_reset: got count=%0d locked=%b expected 5 1", err_count_a, locked_a);
        end
        drive(1, 1, ~gen_next(), 1);
        checks++;
        if (obs_a !== 12'h000 || obs_b !== 12'h000) begin
            failures++;
            $display("FAIL reset_while_locked: got a=%h b=%h expected 000", obs_a, obs_b);
        end
        drive(1, 1, 1'($urandom_range(0, 1)), 0);
        gen_reset();
        for (int i = 1; i <= 40; i++) begin
            drive(0, 1, gen_next(), 0);
            checks++;
            if (obs_a !== exp_vec[0] || obs_b !== exp_vec[1]) begin
                failures++;
                $display("FAIL post_reset bit %0d: got a=%h b=%h expected a=%h b=%h", i, obs_a, obs_b, exp_vec[0], exp_vec[1]);
            end
            if (locked_a && lock_at == 0) lock_at = i;
        end
        checks++;
        if (lock_at != 23) begin
            failures++;
            $display("FAIL post_reset_lock_time: locked after %0d bits, expected 23", lock_at);
        end
    endtask

    task automatic test_random();
        bit v, d, clr, rst;
        gen_reset();
        drive(1, 0, 0, 0);
        for (int i = 0; i < 2500; i++) begin
            rst = ($urandom_range(0, 499) == 0);
            v   = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 49) == 0);
            d   = 1'($urandom_range(0, 1));
            if (v) begin
                d = gen_next();
                if ($urandom_range(0, 11) == 0) d = ~d;
            end
            if (rst) gen_reset();
            drive(rst, v, d, clr);
            checks++;
            if (obs_a !== exp_vec[0] || obs_b !== exp_vec[1]) begin
                failures++;
                $display("FAIL random cyc %0d: got a=%h b=%h expected a=%h b=%h", i, obs_a, obs_b, exp_vec[0], exp_vec[1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_lock();
        test_single_flip();
        test_unlock();
        test_saturate();
        test_zero_input();
        test_gaps();
        test_reset_locked();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
